// File: rtl/ex_mul_sequencer.sv
// Iterative radix-2 shift-add multiply sequencer for the EX stage; stalls the pipe while running.
// Optional early exit on a drained multiplier is enabled by defining MUL_EARLY_EXIT_EN.
module ex_mul_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidE,
  input  logic [2:0]       ALUControlE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             FlushE,
  output logic             MulStallE,
  output logic             MulDoneE,
  output logic [WIDTH-1:0] MulResultE,
  output logic             MulBusy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mplier_shr;
  logic             start;
  logic             last_iter;

  assign mplier_shr = mplier >> 1;
  assign start      = ValidE & (ALUControlE == 3'b010) & (state == IDLE) & ~FlushE & ~rst;

`ifdef MUL_EARLY_EXIT_EN
  assign last_iter = (cnt == CW'(1)) | (mplier_shr == '0);
`else
  assign last_iter = (cnt == CW'(1));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a flush aborts from any state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (FlushE) state_nxt = IDLE;
  end

  // Shift-add datapath: operands captured only at start.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= SrcAE;
      mplier <= SrcBE;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if ((state == RUN) && !FlushE) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier_shr;
      cnt    <= cnt - CW'(1);
    end
  end

  // Stall is combinational from start so the multiply never leaves EX on its first cycle.
  assign MulStallE  = ~rst & ~FlushE & (start | (state == RUN));
  assign MulDoneE   = (state == DONE);
  assign MulBusy    = (state != IDLE);
  assign MulResultE = acc;

endmodule

// File: tb/tb_ex_mul_sequencer.sv
// Self-checking bench for ex_mul_sequencer: vector table, random operands, and multi-cycle corner sequences.
module tb_ex_mul_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ValidE = 1'b0;
  logic [2:0]   ALUControlE = 3'b000;
  logic [W-1:0] SrcAE = '0;
  logic [W-1:0] SrcBE = '0;
  logic         FlushE = 1'b0;
  logic         MulStallE;
  logic         MulDoneE;
  logic [W-1:0] MulResultE;
  logic         MulBusy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  ex_mul_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ValidE     (ValidE),
    .ALUControlE(ALUControlE),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .FlushE     (FlushE),
    .MulStallE  (MulStallE),
    .MulDoneE   (MulDoneE),
    .MulResultE (MulResultE),
    .MulBusy    (MulBusy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
  } vec_t;

  // Reference: product is the low W bits of the full arithmetic product.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] full;
    full = (2*W)'(a) * (2*W)'(b);
    return full[W-1:0];
  endfunction

  // Reference RUN-cycle count for a given multiplier.
  function automatic int exp_run(input logic [W-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int r;
    r = 1;
    for (int i = 0; i < int'(W); i++) if (b[i]) r = i + 1;
    return r;
`else
    return int'(W);
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_stall"}, 64'(MulStallE), 64'd0);
    chk({nm, "_busy"},  64'(MulBusy),   64'd0);
    chk({nm, "_done"},  64'(MulDoneE),  64'd0);
  endtask

  // Drives a multiply, follows it to MulDoneE and checks latency and product. Ends at negedge+1.
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit wait_first, input bit idle_after, output int done_cyc);
    int stalls;
    bit found;
    logic [W-1:0] exp_p;
    exp_p = model(a, b);
    ValidE = 1'b1; ALUControlE = 3'b010; SrcAE = a; SrcBE = b; FlushE = 1'b0;
    if (wait_first) @(negedge clk);
    #1;
    chk("start_stall", 64'(MulStallE), 64'd1);
    stalls = 0;
    found  = 1'b0;
    for (int k = 0; k < 4 * int'(W) && !found; k++) begin
      if (MulDoneE) found = 1'b1;
      else begin
        if (MulStallE) stalls++;
        @(negedge clk);
        SrcAE = $urandom;
        SrcBE = $urandom;
        #1;
      end
    end
    chk("done_seen", 64'(found), 64'd1);
    chk("stall_cycles", 64'(stalls), 64'(exp_run(b) + 1));
    chk("product", 64'(MulResultE), 64'(exp_p));
    chk("stall_in_done", 64'(MulStallE), 64'd0);
    done_cyc = cyc;
    if (idle_after) ValidE = 1'b0;
  endtask

  task automatic chk_after(input logic [W-1:0] exp_p);
    @(negedge clk);
    #1;
    chk("done_one_cycle", 64'(MulDoneE), 64'd0);
    chk("busy_after", 64'(MulBusy), 64'd0);
    chk("result_stable", 64'(MulResultE), 64'(exp_p));
  endtask

  initial begin
    vec_t vecs[6];
    int d1, d2, fl;
    logic [W-1:0] ra, rb;

    vecs[0] = '{a: 32'd3,          b: 32'd5,       p: 32'd15};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd7,       p: 32'hFFFF_FFF9};
    vecs[2] = '{a: 32'h0001_0000,  b: 32'h0001_0000, p: 32'd0};
    vecs[3] = '{a: 32'd12345,      b: 32'd0,       p: 32'd0};
    vecs[4] = '{a: 32'hFFFF_FFFE,  b: 32'hFFFF_FFFD, p: 32'd6};
    vecs[5] = '{a: 32'h8000_0000,  b: 32'd3,       p: 32'h8000_0000};

    // Reset held with a multiply presented.
    ValidE = 1'b1; ALUControlE = 3'b010; SrcAE = 32'd3; SrcBE = 32'd5;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk_quiet("reset");
      chk("reset_result", 64'(MulResultE), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    do_mul(32'd3, 32'd5, 1'b0, 1'b1, d1);
    chk_after(32'd15);

    // Table of fixed vectors.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      do_mul(vecs[i].a, vecs[i].b, 1'b0, 1'b1, d1);
      chk($sformatf("tbl_product_%0d", i), 64'(MulResultE), 64'(vecs[i].p));
      chk_after(vecs[i].p);
    end

    // Non-multiply ops pass through, then multiply bubbles are ignored.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ValidE = 1'b1; ALUControlE = (i % 2 == 1) ? 3'b001 : 3'b000;
      SrcAE = $urandom; SrcBE = $urandom;
      #1;
      chk_quiet("passthru");
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ValidE = 1'b0; ALUControlE = 3'b010;
      #1;
      chk_quiet("bubble");
    end

    // Flush in the middle of a 6 x 7.
    fl = (exp_run(32'd7) - 1 < 10) ? exp_run(32'd7) - 1 : 10;
    @(negedge clk);
    ValidE = 1'b1; ALUControlE = 3'b010; SrcAE = 32'd6; SrcBE = 32'd7;
    #1;
    chk("flush_start_stall", 64'(MulStallE), 64'd1);
    repeat (fl) @(negedge clk);
    #1;
    chk("flush_pre_busy", 64'(MulBusy), 64'd1);
    FlushE = 1'b1;
    #1;
    chk("flush_stall", 64'(MulStallE), 64'd0);
    @(negedge clk);
    FlushE = 1'b0; ValidE = 1'b0;
    #1;
    chk_quiet("flush_after");
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("flush_no_done", 64'(MulDoneE), 64'd0);
    end
    @(negedge clk);
    do_mul(32'd2, 32'd2, 1'b0, 1'b1, d1);
    chk_after(32'd4);

    // Reset in the middle of RUN.
    @(negedge clk);
    ValidE = 1'b1; ALUControlE = 3'b010; SrcAE = 32'h1234; SrcBE = 32'h5678;
    repeat (5) @(negedge clk);
    rst = 1'b1; ValidE = 1'b0;
    @(negedge clk);
    #1;
    chk_quiet("rst_mid");
    chk("rst_mid_result", 64'(MulResultE), 64'd0);
    rst = 1'b0;

    // Random operands against the model.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) rb = 32'd1;
      @(negedge clk);
      do_mul(ra, rb, 1'b0, 1'b1, d1);
      chk_after(model(ra, rb));
    end

    // Back-to-back multiplies.
    @(negedge clk);
    do_mul(32'd9, 32'd9, 1'b0, 1'b0, d1);
    chk("b2b_first", 64'(MulResultE), 64'd81);
    do_mul(32'd4, 32'd8, 1'b1, 1'b1, d2);
    chk("b2b_second", 64'(MulResultE), 64'd32);
    chk("b2b_gap", 64'(d2 - d1), 64'(exp_run(32'd8) + 2));
    chk_after(32'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
